reg_scoreboard: RTL and testbench

Parametrised register-dependency scoreboard for the decode/register-read stage. It replaces per-stage DRID comparators with a per-register outstanding-write counter.
- Counters increment when an instruction issues with destination loads.
- Counters decrement when writeback retires those loads.
- DEP_STALL is raised while any needed source register has outstanding writes.
- Independent of pipeline depth; one instance per register file (GPR, SEG, MM).

---
 rtl/reg_scoreboard_pkg.sv | 24 ++
 rtl/reg_scoreboard_counter.sv | 46 ++++
 rtl/reg_scoreboard.sv | 107 ++++++++++
 tb/tb_reg_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline constants, register-file kinds and the packed-slot helper used by the
// register-dependency scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned NumRegsDefault = 8;
  localparam int unsigned IdWDefault     = $clog2(NumRegsDefault);
  localparam int unsigned MaxVecW        = 64;

  typedef enum logic [1:0] {
    RfGpr,
    RfSeg,
    RfMm
  } regfile_e;

  // Extract slot `slot` of width `w` from a flattened ID vector (zero-extended to MaxVecW).
  function automatic int unsigned slot_id(input logic [MaxVecW-1:0] vec,
                                          input int unsigned         slot,
                                          input int unsigned         w);
    logic [MaxVecW-1:0] mask;
    mask = (MaxVecW'(1) << w) - MaxVecW'(1);
    return 32'((vec >> (slot * w)) & mask);
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register outstanding-write counter: adds issued loads, subtracts retired ones,
// clears on reset/flush and saturates at both ends.
module sb_reg_counter #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned INC_W = 2,
  parameter int unsigned DEC_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [INC_W-1:0] i_inc,
  input  logic [DEC_W-1:0] i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int unsigned SUM_W = CNT_W + INC_W + DEC_W;
  localparam logic [SUM_W-1:0] CntMax = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_net;
  logic             w_under;

  assign w_up    = SUM_W'(r_cnt) + SUM_W'(i_inc);
  assign w_under = w_up < SUM_W'(i_dec);
  assign w_net   = w_up - SUM_W'(i_dec);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_cnt <= '0;
    end else if (w_under) begin
      r_cnt <= '0;
    end else if (w_net > CntMax) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= CNT_W'(w_net);
    end
  end

  assign o_cnt = r_cnt;

  // Retiring more writes than are outstanding means the pipeline lost track of a load.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n || i_flush)
                                   !w_under);

endmodule

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: per-register outstanding-write counters drive the RAW
// stall and overflow stall for the issuing stage.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NumRegsDefault,
  parameter int unsigned ID_W      = IdWDefault,
  parameter int unsigned NUM_SRC   = 6,
  parameter int unsigned NUM_DST   = 2,
  parameter int unsigned NUM_WB    = 2,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    STAGE_V,
  input  logic [NUM_SRC*ID_W-1:0] SRC_ID,
  input  logic [NUM_SRC-1:0]      SRC_NEEDED,
  input  logic [NUM_DST*ID_W-1:0] DST_ID,
  input  logic [NUM_DST-1:0]      DST_LD,
  input  logic [NUM_WB*ID_W-1:0]  WB_ID,
  input  logic [NUM_WB-1:0]       WB_LD,
  output logic                    DEP_STALL,
  output logic                    FULL_STALL,
  output logic                    ISSUE_FIRE,
  output logic [NUM_REGS-1:0]     PENDING,
  output logic                    BUSY
);

  localparam int unsigned DMW    = $clog2(NUM_DST + 1);
  localparam int unsigned WMW    = $clog2(NUM_WB + 1);
  localparam int          CntMax = (1 << CNT_W) - 1;

  logic [CNT_W-1:0]    w_cnt     [NUM_REGS];
  logic [DMW-1:0]      w_dmatch  [NUM_REGS];
  logic [DMW-1:0]      w_inc     [NUM_REGS];
  logic [WMW-1:0]      w_wbmatch [NUM_REGS];
  int                  w_rem     [NUM_REGS];
  logic [NUM_REGS-1:0] w_eff_pend;
  logic [NUM_REGS-1:0] w_over;
  logic                w_dep;

  // Duplicate IDs within one port group each contribute one count.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_dmatch[r]  = '0;
      w_wbmatch[r] = '0;
      for (int unsigned d = 0; d < NUM_DST; d++) begin
        if (DST_LD[d] && slot_id(MaxVecW'(DST_ID), d, ID_W) == r) begin
          w_dmatch[r] = w_dmatch[r] + 1'b1;
        end
      end
      for (int unsigned w = 0; w < NUM_WB; w++) begin
        if (WB_LD[w] && slot_id(MaxVecW'(WB_ID), w, ID_W) == r) begin
          w_wbmatch[r] = w_wbmatch[r] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_rem[r]      = int'(w_cnt[r]) - int'(w_wbmatch[r]);
      w_eff_pend[r] = (WB_BYPASS != 0) ? (w_rem[r] != 0) : (w_cnt[r] != '0);
      w_over[r]     = (w_rem[r] + int'(w_dmatch[r])) > CntMax;
    end
  end

  always_comb begin
    w_dep = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_NEEDED[i] && w_eff_pend[ID_W'(slot_id(MaxVecW'(SRC_ID), i, ID_W))]) begin
        w_dep = 1'b1;
      end
    end
  end

  assign DEP_STALL  = STAGE_V & w_dep;
  assign FULL_STALL = STAGE_V & (|w_over);
  assign ISSUE_FIRE = STAGE_V & ~DEP_STALL & ~FULL_STALL & ~FLUSH;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = ISSUE_FIRE ? w_dmatch[r] : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    sb_reg_counter #(
      .CNT_W (CNT_W),
      .INC_W (DMW),
      .DEC_W (WMW)
    ) u_cnt (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_flush (FLUSH),
      .i_inc   (w_inc[g]),
      .i_dec   (w_wbmatch[g]),
      .o_cnt   (w_cnt[g])
    );
    assign PENDING[g] = (w_cnt[g] != '0);
  end

  assign BUSY = |PENDING;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one instance without and one with writeback bypass,
// driven by the same vectors and checked against hand-computed values.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        stage_v;
  logic [17:0] src_id;
  logic [5:0]  src_needed;
  logic [5:0]  dst_id;
  logic [1:0]  dst_ld;
  logic [5:0]  wb_id;
  logic [1:0]  wb_ld;

  logic       dep0, full0, fire0, busy0;
  logic [7:0] pend0;
  logic       dep1, full1, fire1, busy1;
  logic [7:0] pend1;

  int n_vec = 0;
  int n_err = 0;

  reg_scoreboard #(.WB_BYPASS(0)) u_dut (
    .CLK        (clk),
    .RST        (rst_n),
    .FLUSH      (flush),
    .STAGE_V    (stage_v),
    .SRC_ID     (src_id),
    .SRC_NEEDED (src_needed),
    .DST_ID     (dst_id),
    .DST_LD     (dst_ld),
    .WB_ID      (wb_id),
    .WB_LD      (wb_ld),
    .DEP_STALL  (dep0),
    .FULL_STALL (full0),
    .ISSUE_FIRE (fire0),
    .PENDING    (pend0),
    .BUSY       (busy0)
  );

  reg_scoreboard #(.WB_BYPASS(1)) u_dut_byp (
    .CLK        (clk),
    .RST        (rst_n),
    .FLUSH      (flush),
    .STAGE_V    (stage_v),
    .SRC_ID     (src_id),
    .SRC_NEEDED (src_needed),
    .DST_ID     (dst_id),
    .DST_LD     (dst_ld),
    .WB_ID      (wb_id),
    .WB_LD      (wb_ld),
    .DEP_STALL  (dep1),
    .FULL_STALL (full1),
    .ISSUE_FIRE (fire1),
    .PENDING    (pend1),
    .BUSY       (busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush      = 1'b0;
    stage_v    = 1'b0;
    src_id     = '0;
    src_needed = '0;
    dst_id     = '0;
    dst_ld     = '0;
    wb_id      = '0;
    wb_ld      = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    idle();

    // Reset overrides an issue to r3
    stage_v = 1'b1;
    dst_ld  = 2'b01;
    dst_id  = 6'd3;
    step();
    step();
    check("rst_pend", 32'(pend0), 32'h00);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_pend_byp", 32'(pend1), 32'h00);
    rst_n = 1'b1;
    #1;
    check("rel_fire", 32'(fire0), 32'h1);
    step();
    check("issue3_pend", 32'(pend0), 32'h08);
    check("issue3_busy", 32'(busy0), 32'h1);

    // RAW stall on r3, then retire
    idle();
    stage_v    = 1'b1;
    src_id     = 18'd3;
    src_needed = 6'b000001;
    #1;
    check("raw_dep", 32'(dep0), 32'h1);
    check("raw_fire", 32'(fire0), 32'h0);
    check("raw_dep_byp", 32'(dep1), 32'h1);
    wb_ld = 2'b01;
    wb_id = 6'd3;
    #1;
    check("wb_dep_nobyp", 32'(dep0), 32'h1);
    check("wb_dep_byp", 32'(dep1), 32'h0);
    check("wb_fire_byp", 32'(fire1), 32'h1);
    step();
    wb_ld = 2'b00;
    #1;
    check("post_wb_dep", 32'(dep0), 32'h0);
    check("post_wb_fire", 32'(fire0), 32'h1);
    check("post_wb_pend", 32'(pend0), 32'h00);

    // Source not needed does not stall
    idle();
    stage_v = 1'b1;
    dst_ld  = 2'b01;
    dst_id  = 6'd3;
    step();
    dst_ld     = 2'b00;
    src_id     = 18'd3;
    src_needed = 6'b000000;
    #1;
    check("noneed_dep", 32'(dep0), 32'h0);
    check("noneed_fire", 32'(fire0), 32'h1);
    check("noneed_pend", 32'(pend0), 32'h08);
    idle();
    wb_ld = 2'b01;
    wb_id = 6'd3;
    step();
    check("clear3_pend", 32'(pend0), 32'h00);
    check("clear3_pend_byp", 32'(pend1), 32'h00);

    // Counter fills to 3 on r5, fourth issue overflows
    idle();
    stage_v = 1'b1;
    dst_ld  = 2'b01;
    dst_id  = 6'd5;
    step();
    step();
    step();
    check("fill5_pend", 32'(pend0), 32'h20);
    check("fill5_full", 32'(full0), 32'h1);
    check("fill5_fire", 32'(fire0), 32'h0);
    check("fill5_full_byp", 32'(full1), 32'h1);
    step();
    check("stall5_pend", 32'(pend0), 32'h20);
    wb_ld = 2'b01;
    wb_id = 6'd5;
    #1;
    check("full_wb_full", 32'(full0), 32'h0);
    check("full_wb_fire", 32'(fire0), 32'h1);
    step();
    idle();
    stage_v    = 1'b1;
    src_id     = {3'd5, 15'd0};
    src_needed = 6'b100000;
    #1;
    check("slot5_dep", 32'(dep0), 32'h1);
    check("slot5_fire", 32'(fire0), 32'h0);
    stage_v = 1'b0;
    #1;
    check("nov_dep", 32'(dep0), 32'h0);
    check("nov_full", 32'(full0), 32'h0);
    check("nov_fire", 32'(fire0), 32'h0);
    wb_ld = 2'b11;
    wb_id = {3'd5, 3'd5};
    step();
    check("ret2_pend", 32'(pend0), 32'h20);
    wb_ld = 2'b01;
    step();
    check("ret1_pend", 32'(pend0), 32'h00);

    // Duplicate destinations and net-zero issue/retire on r2
    idle();
    stage_v = 1'b1;
    dst_ld  = 2'b11;
    dst_id  = {3'd2, 3'd2};
    step();
    check("dup_pend", 32'(pend0), 32'h04);
    dst_ld = 2'b01;
    wb_ld  = 2'b01;
    wb_id  = 6'd2;
    #1;
    check("net0_fire", 32'(fire0), 32'h1);
    step();
    check("net0_pend", 32'(pend0), 32'h04);
    idle();
    wb_ld = 2'b11;
    wb_id = {3'd2, 3'd2};
    step();
    check("dupwb_pend", 32'(pend0), 32'h00);
    check("dupwb_busy", 32'(busy0), 32'h0);

    // Flush with work in flight
    idle();
    stage_v = 1'b1;
    dst_ld  = 2'b11;
    dst_id  = {3'd1, 3'd1};
    step();
    dst_ld = 2'b01;
    dst_id = {3'd0, 3'd6};
    step();
    check("preflush_pend", 32'(pend0), 32'h42);
    flush  = 1'b1;
    dst_id = 6'd4;
    #1;
    check("flush_fire", 32'(fire0), 32'h0);
    check("flush_fire_byp", 32'(fire1), 32'h0);
    step();
    check("flush_pend", 32'(pend0), 32'h00);
    check("flush_busy", 32'(busy0), 32'h0);
    check("flush_pend_byp", 32'(pend1), 32'h00);
    idle();
    step();
    check("idle_pend", 32'(pend0), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
